// File: rtl/round_scorer_pkg.sv
// Shared game definitions: FSM encodings, round length default, scoring-stage codes
// and a small integer-to-BCD helper for elaboration-time constants.
package round_scorer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ROUND_SECS_DEFAULT = 30;

  typedef enum logic [1:0] {
    SC_NONE  = 2'd0,
    SC_VALID = 2'd1,
    SC_ACK   = 2'd2
  } score_ctl_t;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/round_scorer_if.sv
// Game control inputs and BCD display / scoring-stage outputs of round_scorer.
interface round_scorer_if;
  logic       start;
  logic       abort;
  logic       tick;
  logic       hit;
  logic       miss;
  logic       scoreAck;
  logic [3:0] scoreOnes;
  logic [3:0] scoreTens;
  logic [3:0] timeOnes;
  logic [3:0] timeTens;
  logic       playing;
  logic       scoreValid;

  modport master (
    output start, abort, tick, hit, miss, scoreAck,
    input  scoreOnes, scoreTens, timeOnes, timeTens, playing, scoreValid
  );

  modport slave (
    input  start, abort, tick, hit, miss, scoreAck,
    output scoreOnes, scoreTens, timeOnes, timeTens, playing, scoreValid
  );
endinterface

// File: rtl/round_scorer_bcd_counter2.sv
// Two-digit BCD up/down counter with clear and load; saturates at 99 and 00.
// Priority: clear, load, then inc/dec (both together hold the value).
module bcd_counter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  logic at_max;
  logic at_min;

  assign at_max = (ones == 4'd9) && (tens == 4'd9);
  assign at_min = (ones == 4'd0) && (tens == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (clear) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (load) begin
      ones <= load_val[3:0];
      tens <= load_val[7:4];
    end else if (inc && !dec && !at_max) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end else if (dec && !inc && !at_min) begin
      if (ones == 4'd0) begin
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/round_scorer.sv
// Timed scoring round: IDLE -> PLAY on start, PLAY -> DONE when the BCD timer
// runs out, DONE -> IDLE on scoreAck; abort drops back to IDLE from PLAY or DONE.
module round_scorer
  import round_scorer_pkg::*;
#(
  parameter int ROUND_SECS = ROUND_SECS_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  round_scorer_if.slave  bus
);

  localparam logic [7:0] TIME_INIT = to_bcd(ROUND_SECS);

  state_t state;
  logic   playing_q;
  logic   valid_q;
  logic   go;
  logic   kill;
  logic   in_play;
  logic   last_tick;

  assign go        = bus.start && (state == IDLE);
  assign kill      = bus.abort && (state != IDLE);
  assign in_play   = (state == PLAY) && !bus.abort;
  assign last_tick = in_play && bus.tick && (bus.timeTens == 4'd0) && (bus.timeOnes == 4'd1);

  bcd_counter2 u_score (
    .clk      (clk),
    .rst      (rst),
    .clear    (go || kill),
    .load     (1'b0),
    .load_val (8'h00),
    .inc      (in_play && bus.hit),
    .dec      (in_play && bus.miss),
    .ones     (bus.scoreOnes),
    .tens     (bus.scoreTens)
  );

  bcd_counter2 u_time (
    .clk      (clk),
    .rst      (rst),
    .clear    (kill),
    .load     (go),
    .load_val (TIME_INIT),
    .inc      (1'b0),
    .dec      (in_play && bus.tick),
    .ones     (bus.timeOnes),
    .tens     (bus.timeTens)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      playing_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state     <= PLAY;
            playing_q <= 1'b1;
          end
        end
        PLAY: begin
          if (bus.abort) begin
            state     <= IDLE;
            playing_q <= 1'b0;
          end else if (last_tick) begin
            state     <= DONE;
            playing_q <= 1'b0;
            valid_q   <= 1'b1;
          end
        end
        DONE: begin
          if (bus.abort || bus.scoreAck) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          playing_q <= 1'b0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.playing    = playing_q;
  assign bus.scoreValid = valid_q;

endmodule

// File: tb/tb_round_scorer.sv
// Directed bench for round_scorer: a vector table for the basic flow, then
// hand sequences for saturation, carries, round end, abort and async reset.
module tb_round_scorer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  round_scorer_if ifa ();
  round_scorer_if ifb ();

  round_scorer #(.ROUND_SECS(30)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  round_scorer #(.ROUND_SECS(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // input bit order: {start, abort, tick, hit, miss, scoreAck}
  localparam logic [5:0] N  = 6'b000000;
  localparam logic [5:0] ST = 6'b100000;
  localparam logic [5:0] AB = 6'b010000;
  localparam logic [5:0] TK = 6'b001000;
  localparam logic [5:0] HT = 6'b000100;
  localparam logic [5:0] MS = 6'b000010;
  localparam logic [5:0] AK = 6'b000001;

  typedef struct {
    logic [5:0] in;
    logic [7:0] sc;
    logic [7:0] tm;
    logic       pl;
    logic       vd;
    string      nm;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [17:0] obs(input bit b);
    if (b)
      return {ifb.scoreTens, ifb.scoreOnes, ifb.timeTens, ifb.timeOnes, ifb.playing, ifb.scoreValid};
    return {ifa.scoreTens, ifa.scoreOnes, ifa.timeTens, ifa.timeOnes, ifa.playing, ifa.scoreValid};
  endfunction

  task automatic set_in(input bit b, input logic [5:0] v);
    if (b) {ifb.start, ifb.abort, ifb.tick, ifb.hit, ifb.miss, ifb.scoreAck} = v;
    else   {ifa.start, ifa.abort, ifa.tick, ifa.hit, ifa.miss, ifa.scoreAck} = v;
  endtask

  task automatic step(input bit b, input logic [5:0] v);
    set_in(b, v);
    @(posedge clk);
    #1;
    set_in(1'b0, N);
    set_in(1'b1, N);
  endtask

  task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual score/time/play/valid=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_all(input bit b, input string nm, input logic [7:0] sc,
                           input logic [7:0] tm, input logic pl, input logic vd);
    check(nm, obs(b), {sc, tm, pl, vd});
  endtask

  task automatic repeat_step(input bit b, input logic [5:0] v, input int n);
    for (int i = 0; i < n; i++) step(b, v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    set_in(1'b0, N);
    set_in(1'b1, N);

    tbl[0]  = '{N,       8'h00, 8'h00, 1'b0, 1'b0, "reset_state"};
    tbl[1]  = '{ST,      8'h00, 8'h30, 1'b1, 1'b0, "start_load"};
    tbl[2]  = '{HT,      8'h01, 8'h30, 1'b1, 1'b0, "hit1"};
    tbl[3]  = '{HT,      8'h02, 8'h30, 1'b1, 1'b0, "hit2"};
    tbl[4]  = '{HT,      8'h03, 8'h30, 1'b1, 1'b0, "hit3"};
    tbl[5]  = '{MS,      8'h02, 8'h30, 1'b1, 1'b0, "miss1"};
    tbl[6]  = '{HT | MS, 8'h02, 8'h30, 1'b1, 1'b0, "hit_miss_same"};
    tbl[7]  = '{TK,      8'h02, 8'h29, 1'b1, 1'b0, "tick30"};
    tbl[8]  = '{ST,      8'h02, 8'h29, 1'b1, 1'b0, "start_in_play"};
    tbl[9]  = '{AK,      8'h02, 8'h29, 1'b1, 1'b0, "ack_in_play"};
    tbl[10] = '{MS,      8'h01, 8'h29, 1'b1, 1'b0, "miss_to_01"};
    tbl[11] = '{MS,      8'h00, 8'h29, 1'b1, 1'b0, "miss_to_00"};
    tbl[12] = '{MS,      8'h00, 8'h29, 1'b1, 1'b0, "miss_floor1"};
    tbl[13] = '{MS,      8'h00, 8'h29, 1'b1, 1'b0, "miss_floor2"};

    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    check_all(1'b0, "reset_pre", 8'h00, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      step(1'b0, tbl[i].in);
      check_all(1'b0, tbl[i].nm, tbl[i].sc, tbl[i].tm, tbl[i].pl, tbl[i].vd);
    end

    // carries in score and time
    repeat_step(1'b0, HT, 9);
    check_all(1'b0, "score_09", 8'h09, 8'h29, 1'b1, 1'b0);
    step(1'b0, HT);
    check_all(1'b0, "score_09_to_10", 8'h10, 8'h29, 1'b1, 1'b0);
    repeat_step(1'b0, TK, 19);
    check_all(1'b0, "time_10", 8'h10, 8'h10, 1'b1, 1'b0);
    step(1'b0, TK);
    check_all(1'b0, "time_10_to_09", 8'h10, 8'h09, 1'b1, 1'b0);

    // abort at 17
    repeat_step(1'b0, HT, 7);
    check_all(1'b0, "score_17", 8'h17, 8'h09, 1'b1, 1'b0);
    step(1'b0, AB);
    check("abort_score", {10'd0, ifa.scoreTens, ifa.scoreOnes}, 18'h00);
    check("abort_play_valid", {16'd0, ifa.playing, ifa.scoreValid}, 18'd0);
    step(1'b0, N);
    step(1'b0, HT);
    check("abort_idle_quiet", {10'd0, ifa.scoreTens, ifa.scoreOnes, ifa.playing, ifa.scoreValid}, 18'd0);

    // hit+miss at 05, saturation at 99
    step(1'b0, ST);
    check_all(1'b0, "restart", 8'h00, 8'h30, 1'b1, 1'b0);
    repeat_step(1'b0, HT, 5);
    step(1'b0, HT | MS);
    check_all(1'b0, "hit_miss_at_05", 8'h05, 8'h30, 1'b1, 1'b0);
    repeat_step(1'b0, HT, 93);
    check_all(1'b0, "score_98", 8'h98, 8'h30, 1'b1, 1'b0);
    repeat_step(1'b0, HT, 3);
    check_all(1'b0, "score_sat_99", 8'h99, 8'h30, 1'b1, 1'b0);

    // final tick coincident with hit at 41, then DONE behaviour
    step(1'b0, AB);
    step(1'b0, ST);
    repeat_step(1'b0, HT, 41);
    repeat_step(1'b0, TK, 29);
    check_all(1'b0, "pre_final", 8'h41, 8'h01, 1'b1, 1'b0);
    step(1'b0, TK | HT);
    check_all(1'b0, "final_tick_hit", 8'h42, 8'h00, 1'b0, 1'b1);
    step(1'b0, ST);
    check_all(1'b0, "done_start", 8'h42, 8'h00, 1'b0, 1'b1);
    step(1'b0, TK);
    check_all(1'b0, "done_tick", 8'h42, 8'h00, 1'b0, 1'b1);
    step(1'b0, HT);
    check_all(1'b0, "done_hit", 8'h42, 8'h00, 1'b0, 1'b1);
    step(1'b0, MS);
    check_all(1'b0, "done_miss", 8'h42, 8'h00, 1'b0, 1'b1);
    step(1'b0, AK);
    check_all(1'b0, "ack_to_idle", 8'h42, 8'h00, 1'b0, 1'b0);
    step(1'b0, N);
    check_all(1'b0, "idle_hold", 8'h42, 8'h00, 1'b0, 1'b0);

    // asynchronous reset mid-round, asserted between clock edges
    step(1'b0, ST);
    repeat_step(1'b0, HT, 3);
    check_all(1'b0, "pre_rst", 8'h03, 8'h30, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    check_all(1'b0, "async_rst", 8'h00, 8'h00, 1'b0, 1'b0);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, HT);
    step(1'b0, TK);
    check_all(1'b0, "post_rst_idle", 8'h00, 8'h00, 1'b0, 1'b0);

    // short round on the ROUND_SECS=2 instance
    step(1'b1, ST);
    check_all(1'b1, "r2_start", 8'h00, 8'h02, 1'b1, 1'b0);
    step(1'b1, HT);
    check_all(1'b1, "r2_hit", 8'h01, 8'h02, 1'b1, 1'b0);
    step(1'b1, TK);
    check_all(1'b1, "r2_tick1", 8'h01, 8'h01, 1'b1, 1'b0);
    step(1'b1, TK);
    check_all(1'b1, "r2_done", 8'h01, 8'h00, 1'b0, 1'b1);
    step(1'b1, AK);
    check_all(1'b1, "r2_ack", 8'h01, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
